// File: rtl/stream_pkg.sv
// Shared constants for the two-channel stream merge: channel indices and
// the packet-lock state encoding used when STREAM_MUX2_PKT_LOCK_EN is defined.
package stream_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_LOCKED0  = 2'd1,
    LK_LOCKED1  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/stream_mux2_if.sv
// Bundle of the two input streams and the merged output stream of stream_mux2.
// Handshake: a beat moves across a channel on a rising clk edge where valid && ready
// are both high; valid must not wait for ready, and payload/last are only meaningful with valid.
interface stream_mux2_if #(
  parameter int WIDTH = 8
) ();

  logic             in0_valid;
  logic             in0_last;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;

  logic             in1_valid;
  logic             in1_last;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;
  logic             out_ready;

  modport slave (
    input  in0_valid, in0_last, in0_data,
    output in0_ready,
    input  in1_valid, in1_last, in1_data,
    output in1_ready,
    output out_valid, out_data, out_last, out_sel,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_last, in0_data,
    input  in0_ready,
    output in1_valid, in1_last, in1_data,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_sel,
    output out_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins, a tie goes to rr,
// and an active lock pins the grant to lock_ch.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       lock,
  input  logic       lock_ch,
  output logic       grant
);

  always_comb begin
    grant = rr;
    if (lock) begin
      grant = lock_ch;
    end else if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux2.sv
// stream_mux2: merges two valid/ready streams into one registered output slot.
// Define STREAM_MUX2_PKT_LOCK_EN to hold the grant on a channel until its last beat.
module stream_mux2
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux2_if.slave  s_bus,
  output logic [1:0]    o_dbg_state,
  output logic          o_dbg_rr
);

  localparam logic [1:0] ST_UNLOCKED = 2'(LK_UNLOCKED);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_sel;
  logic             r_rr;

  logic             w_free;
  logic             w_grant;
  logic             w_lock;
  logic             w_lock_ch;
  logic             w_in0_ready;
  logic             w_in1_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  rr_arb2 u_arb (
    .req     ({s_bus.in1_valid, s_bus.in0_valid}),
    .rr      (r_rr),
    .lock    (w_lock),
    .lock_ch (w_lock_ch),
    .grant   (w_grant)
  );

  // The slot can take a new beat when empty or when its beat leaves this edge.
  assign w_free      = !r_out_valid || s_bus.out_ready;
  assign w_in0_ready = !rst && w_free && (w_grant == CH0);
  assign w_in1_ready = !rst && w_free && (w_grant == CH1);
  assign w_accept    = (w_in0_ready && s_bus.in0_valid) || (w_in1_ready && s_bus.in1_valid);
  assign w_sel_data  = (w_grant == CH1) ? s_bus.in1_data : s_bus.in0_data;
  assign w_sel_last  = (w_grant == CH1) ? s_bus.in1_last : s_bus.in0_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= CH0;
      r_rr        <= CH0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_grant;
      r_rr        <= ~w_grant;
    end else if (s_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX2_PKT_LOCK_EN
  localparam logic [1:0] ST_LOCKED0 = 2'(LK_LOCKED0);
  localparam logic [1:0] ST_LOCKED1 = 2'(LK_LOCKED1);

  logic [1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_accept && !w_sel_last) begin
            r_state <= (w_grant == CH1) ? ST_LOCKED1 : ST_LOCKED0;
          end
        end
        ST_LOCKED0, ST_LOCKED1: begin
          if (w_accept && w_sel_last) begin
            r_state <= ST_UNLOCKED;
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

  assign w_lock      = (r_state != ST_UNLOCKED);
  assign w_lock_ch   = (r_state == ST_LOCKED1);
  assign o_dbg_state = r_state;
`else
  assign w_lock      = 1'b0;
  assign w_lock_ch   = CH0;
  assign o_dbg_state = ST_UNLOCKED;
`endif

  assign s_bus.in0_ready = w_in0_ready;
  assign s_bus.in1_ready = w_in1_ready;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.out_data  = r_out_data;
  assign s_bus.out_last  = r_out_last;
  assign s_bus.out_sel   = r_out_sel;
  assign o_dbg_rr        = r_rr;

endmodule

// File: tb/tb_stream_mux2.sv
// Directed bench for stream_mux2; lock scenarios compile in when
// STREAM_MUX2_PKT_LOCK_EN is defined.
module tb_stream_mux2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       dbg_rr;
  int         n_checks;
  int         n_pass;
  logic [8:0] exp_q[$];

  stream_mux2_if #(.WIDTH(8)) bus ();

  stream_mux2 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_bus       (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_rr    (dbg_rr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in0_valid = 1'b0; bus.in0_last = 1'b0; bus.in0_data = 8'h00;
    bus.in1_valid = 1'b0; bus.in1_last = 1'b0; bus.in1_data = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    bus.in0_valid = 1'b1; bus.in0_data = 8'hEE; bus.in0_last = 1'b1;
    bus.in1_valid = 1'b1; bus.in1_data = 8'hDD; bus.in1_last = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else n_pass++;
    n_checks++; if (bus.out_sel !== 1'b0) $display("FAIL rst_out_sel: got %b want 0", bus.out_sel); else n_pass++;
    n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b00) $display("FAIL rst_in_ready: got %b want 00", {bus.in1_ready, bus.in0_ready}); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (dbg_rr !== 1'b0) $display("FAIL rst_rr: got %b want 0", dbg_rr); else n_pass++;
  endtask

  task automatic test_only_in1();
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 8'h5A; bus.in1_last = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b10) $display("FAIL in1_only_ready: got %b want 10", {bus.in1_ready, bus.in0_ready}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in1_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL in1_only_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sel !== 1'b1) $display("FAIL in1_only_sel: got %b want 1", bus.out_sel); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h5A) $display("FAIL in1_only_data: got %h want 5A", bus.out_data); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 8'hA5; bus.in0_last = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in0_ready !== 1'b1) $display("FAIL single_in0_ready: got %b want 1", bus.in0_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in0_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL single_data: got %h want A5", bus.out_data); else n_pass++;
    n_checks++; if ({bus.out_sel, bus.out_last} !== 2'b01) $display("FAIL single_sel_last: got %b want 01", {bus.out_sel, bus.out_last}); else n_pass++;
    n_checks++; if (dbg_rr !== 1'b1) $display("FAIL single_rr: got %b want 1", dbg_rr); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_beat;
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 8'hA0; bus.in0_last = 1'b1;
    bus.in1_valid = 1'b1; bus.in1_data = 8'hB1; bus.in1_last = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hB1});
    #1;
    n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) $display("FAIL b2b_first_grant: got %b want 01", {bus.in1_ready, bus.in0_ready}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_beat = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_beat)
        $display("FAIL b2b_beat%0d: got valid=%b sel=%b data=%h want valid=1 sel=%b data=%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, exp_beat[8], exp_beat[7:0]);
      else n_pass++;
    end
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 8'h3C; bus.in0_last = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in0_data  = 8'h4D;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h77; bus.in1_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) $display("FAIL stall_hold%0d: got valid=%b data=%h want valid=1 data=3C", i, bus.out_valid, bus.out_data); else n_pass++;
      n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b00) $display("FAIL stall_ready%0d: got %b want 00", i, {bus.in1_ready, bus.in0_ready}); else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b10) $display("FAIL stall_release_ready: got %b want 10", {bus.in1_ready, bus.in0_ready}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    n_checks++; if ({bus.out_sel, bus.out_data} !== {1'b1, 8'h77}) $display("FAIL stall_next_beat: got sel=%b data=%h want sel=1 data=77", bus.out_sel, bus.out_data); else n_pass++;
  endtask

`ifdef STREAM_MUX2_PKT_LOCK_EN
  task automatic test_lock();
    logic [7:0] pk [3];
    pk = '{8'h11, 8'h22, 8'h33};
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 8'h99; bus.in1_last = 1'b1;
    bus.in0_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in0_data = pk[i];
      bus.in0_last = (i == 2);
      #1;
      n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) $display("FAIL lock_ready%0d: got %b want 01", i, {bus.in1_ready, bus.in0_ready}); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if ({bus.out_sel, bus.out_data} !== {1'b0, pk[i]}) $display("FAIL lock_beat%0d: got sel=%b data=%h want sel=0 data=%h", i, bus.out_sel, bus.out_data, pk[i]); else n_pass++;
      n_checks++; if (dbg_state !== ((i < 2) ? 2'd1 : 2'd0)) $display("FAIL lock_state%0d: got %0d want %0d", i, dbg_state, (i < 2) ? 1 : 0); else n_pass++;
    end
    n_checks++; if (dbg_rr !== 1'b1) $display("FAIL lock_rr_after: got %b want 1", dbg_rr); else n_pass++;
    bus.in0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in1_valid = 1'b0;
    n_checks++; if ({bus.out_sel, bus.out_data} !== {1'b1, 8'h99}) $display("FAIL lock_in1_follows: got sel=%b data=%h want sel=1 data=99", bus.out_sel, bus.out_data); else n_pass++;
  endtask

  task automatic test_lock_reset();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 8'h11; bus.in0_last = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h99; bus.in1_last = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in0_data = 8'h22;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL lrst_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0 || dbg_rr !== 1'b0) $display("FAIL lrst_state_rr: got state=%0d rr=%b want state=0 rr=0", dbg_state, dbg_rr); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) $display("FAIL lrst_first_grant: got %b want 01", {bus.in1_ready, bus.in0_ready}); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    n_checks++; if ({bus.out_sel, bus.out_data} !== {1'b0, 8'h22}) $display("FAIL lrst_post_beat: got sel=%b data=%h want sel=0 data=22", bus.out_sel, bus.out_data); else n_pass++;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_only_in1();
    test_single();
    test_back_to_back();
    test_stall();
`ifdef STREAM_MUX2_PKT_LOCK_EN
    test_lock();
    test_lock_reset();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux2.md
STREAM_MUX2 -- requirements
Module: stream_mux2

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width of every channel.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in0_valid, in0_last  input  1 each  channel 0 beat present / final beat of a packet.
REQ-005 in0_data  input  WIDTH  channel 0 payload.
REQ-006 in0_ready  output  1  channel 0 beat accepted when in0_valid && in0_ready at an edge.
REQ-007 in1_valid, in1_last, in1_data, in1_ready: same as REQ-004 to REQ-006 for channel 1.
REQ-008 out_valid  output  1  registered output beat present.
REQ-009 out_data  output  WIDTH  registered payload.
REQ-010 out_last  output  1  registered last flag.
REQ-011 out_sel  output  1  source channel of the current output beat (0 or 1); the select that a downstream demux consumes.
REQ-012 out_ready  input  1  downstream accepts a beat when out_valid && out_ready at an edge.

Function
REQ-013 The block SHALL merge two valid/ready streams into one through a single registered output slot.
REQ-014 Slot free condition: free = !out_valid || out_ready.
REQ-015 Grant: if only one input is valid, that input SHALL win; if both are valid, the channel named by the priority pointer rr SHALL win.
REQ-016 inK_ready SHALL equal free && (grant == K); at most one inK_ready is high in any cycle; inK_ready SHALL not depend on inK_valid of the other channel except through grant.
REQ-017 On acceptance, out_data, out_last and out_sel SHALL be loaded and out_valid SHALL be set at the same edge, giving 1-cycle latency.
REQ-018 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-019 When out_valid && !out_ready, out_data, out_last and out_sel SHALL hold stable and both in_ready signals SHALL be 0.
REQ-020 When the slot drains (out_valid && out_ready) and no input is accepted, out_valid SHALL clear at that edge.
REQ-021 rr SHALL update to the other channel after each accepted beat from the granted channel (per-beat mode, REQ-026).
REQ-022 Lock state machine: UNLOCKED and LOCKED(k).
  - UNLOCKED -> LOCKED(k) when a beat is accepted from channel k with inK_last = 0.
  - LOCKED(k) -> UNLOCKED when a beat is accepted from channel k with inK_last = 1; rr then becomes the other channel.
  - In LOCKED(k), grant SHALL be k regardless of the other channel's valid.
REQ-023 A single-beat packet (last = 1 on its first beat) SHALL leave the state UNLOCKED and update rr.

Reset
REQ-024 While rst is high, the block SHALL force out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, rr = 0, state = UNLOCKED, and both in_ready = 0.
REQ-025 Assertion of rst mid-packet or mid-stall SHALL discard the slot contents and the lock; no beat SHALL be accepted on the reset edge.

Configuration
REQ-026 Macro STREAM_MUX2_PKT_LOCK_EN controls packet locking.
  - Defined: REQ-022 and REQ-023 SHALL be in force.
  - Undefined: the lock state machine SHALL be absent, arbitration SHALL be per beat (REQ-021), and inK_last SHALL only be passed through to out_last.

Structure
REQ-027 A shared package stream_pkg SHALL hold the channel-index constants (CH0 = 0, CH1 = 1) and the lock-state enumeration.
REQ-028 A single sub-module rr_arb2 SHALL implement the two-request round-robin grant (inputs: req[1:0], rr, lock, lock_ch; output: grant).
REQ-029 The datapath, slot register and FSM SHALL reside in stream_mux2.

Verification
REQ-030 Reset release, in0 sends 8'hA5 with out_ready = 1 -> next cycle out_valid = 1, out_data = A5, out_sel = 0.
REQ-031 Both inputs valid continuously, out_ready = 1, macro undefined -> out_sel sequence 0,1,0,1 with one beat per cycle.
REQ-032 out_ready = 0 for 3 cycles while out_data = 8'h3C -> out_data held at 3C, in0_ready = in1_ready = 0; first cycle with out_ready = 1 -> next beat loaded.
REQ-033 Macro defined, in0 sends a 3-beat packet (11, 22, 33; last on 33) while in1 is valid throughout -> out_sel = 0,0,0, then in1's beat follows.
REQ-034 rst asserted during beat 2 of a locked packet -> next cycle out_valid = 0, state UNLOCKED, rr = 0; in0 wins the first post-reset contention.
REQ-035 Only in1 valid with rr = 0 -> in1 is granted immediately with no idle cycle.
